johnson_counter_16: RTL and testbench
=====================================

// Module: johnson_counter_16
// PURPOSE
//   Free-running 16-bit Johnson (twisted-ring) counter with 32 states. Outputs the
//   ring value plus a binary phase index, a wrap strobe and a fault flag.
//   Used as a glitch-free multi-phase sequencer / timing generator.
//   The block has no enable: it advances on every clock edge while out of reset.
// PARAMETERS
//   WIDTH    16   Ring length in bits. This block is specified and verified for 16 only.
//   PHASE_W  5    Phase index width, equal to clog2(2*WIDTH).
// PORTS
//   clk      in   1      Rising-edge clock. It is the only clock.
//   reset    in   1      Asynchronous, active-low reset. 0 = held in reset.
//   out      out  16     Johnson ring register (registered).
//   phase    out  5      Index 0..31 of the current state (combinational from out).
//   wrap     out  1      Registered 1-cycle pulse when state 31 -> 0 has occurred.
//   illegal  out  1      Combinational. 1 when out is not one of the 32 legal states.
// BEHAVIOUR
// - Reset (reset=0, asynchronous, no clock needed):
//   - out = 16'h0000 and wrap = 0.
//   - phase = 0 and illegal = 0 follow from out.
//   - Deassertion is synchronised by the integrator. The first advance happens on
//     the first rising clk edge with reset=1.
// - Advance on each rising edge: out <= {out[14:0], ~out[15]}. This is a left shift
//   with the inverted MSB fed into the LSB.
//   - Sequence: 0000, 0001, 0003, 0007, ..., 7FFF, FFFF, FFFE, FFFC, ..., 8000, 0000.
//   - The period is exactly 32 cycles.
// - Exactly one bit changes per cycle in the legal sequence, giving a Hamming distance of 1.
// - Legal states have at most one adjacent-bit transition, i.e. (out[i] != out[i+1])
//   for at most one i in 0..14.
//   - The 32 legal states are: all-zeros, all-ones, 0..01..1 and 1..10..0.
//   - illegal = 1 when two or more adjacent-bit transitions exist.
// - Self-correction: if illegal = 1 at a clock edge, the next out is 16'h0000
//   instead of the shift value. Recovery therefore takes 1 cycle.
// - Phase decode:
//   - If out[15] = 0: phase = popcount(out), giving 0..15.
//   - Otherwise: phase = 16 + popcount(~out), giving 16..31.
//   - Examples: 0000->0, 0001->1, FFFF->16, FFFE->17, 8000->31.
//   - When illegal = 1, phase is forced to 0.
// - wrap:
//   - It is registered high in the cycle where out = 0000 following 8000 (normal wrap).
//   - It stays 0 on entry to 0000 from reset or from self-correction.
//   - High for 1 cycle every 32 cycles in steady state.
// - Reset mid-count: out returns to 0000 immediately and wrap clears.
//   - The count restarts at 0001 on the next edge after release.
// - No X propagation: all registers have reset values.
// TESTING
// 1. Reset held low, clk toggling -> out = 0000, phase = 0, wrap = 0, illegal = 0
//    on every cycle.
// 2. Release reset and run 40 edges.
//    -> out = 0001, 0003, 0007, ... FFFF, FFFE, ... 8000, 0000, 0001.
//    -> phase equals the edge count mod 32.
//    -> Each transition has exactly one bit change.
// 3. Steady run for 96 cycles -> wrap pulses exactly at cycles 32, 64 and 96 with
//    width 1. It is never high after reset release.
// 4. Assert reset asynchronously (mid-clock-period) while out = 00FF.
//    -> out = 0000 before the next clk edge.
//    -> After release the next state is 0001.
// 5. Force/deposit out = 16'h0005.
//    -> illegal = 1 and phase = 0.
//    -> Next edge: out = 0000, illegal = 0, wrap = 0. Counting then resumes at 0001.
// 6. Phase spot checks against the decode table: 7FFF -> 15, FFFF -> 16, FFF0 -> 20,
//    8000 -> 31.

Source files
------------

// File: rtl/johnson_counter_16.sv
// 16-bit Johnson (twisted-ring) counter with 32 states.
// Outputs:
//   out     - the ring register
//   phase   - binary phase index decoded from the ring
//   wrap    - registered pulse on the normal 31 -> 0 wrap
//   illegal - flags any ring value outside the 32-state sequence
// An illegal ring value is replaced by all-zeros on the next edge, so the
// counter recovers in one cycle.
module johnson_counter_16 #(
    parameter int WIDTH   = 16,
    parameter int PHASE_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    output logic [WIDTH-1:0]   out,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic               illegal
);

    // Last state of the sequence (MSB set, rest clear); the next state wraps to zero.
    localparam logic [WIDTH-1:0] LAST_STATE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-2:0]   adj_diff;
    logic [PHASE_W-1:0] diff_cnt;
    logic [PHASE_W-1:0] ones_cnt;
    logic [PHASE_W-1:0] zeros_cnt;
    logic [WIDTH-1:0]   out_next;
    logic               wrap_next;

    // A legal Johnson state has at most one place where neighbouring bits differ.
    assign adj_diff = out[WIDTH-2:0] ^ out[WIDTH-1:1];

    // Count adjacent-bit transitions, ones and zeros of the ring value.
    always_comb begin
        diff_cnt  = '0;
        ones_cnt  = '0;
        zeros_cnt = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            diff_cnt = diff_cnt + PHASE_W'(adj_diff[i]);
        end
        for (int i = 0; i < WIDTH; i++) begin
            ones_cnt  = ones_cnt + PHASE_W'(out[i]);
            zeros_cnt = zeros_cnt + PHASE_W'(~out[i]);
        end
    end

    // Legality flag and phase decode. The filling half (MSB clear) is indexed
    // by the number of ones; the draining half continues from WIDTH by the
    // number of zeros. Illegal values decode to phase 0.
    always_comb begin
        illegal = (diff_cnt > PHASE_W'(1));
        phase   = '0;
        if (!illegal) begin
            if (!out[WIDTH-1]) begin
                phase = ones_cnt;
            end else begin
                phase = PHASE_W'(WIDTH) + zeros_cnt;
            end
        end
    end

    // Next ring value: twisted shift, or all-zeros to recover from an illegal value.
    always_comb begin
        out_next  = {out[WIDTH-2:0], ~out[WIDTH-1]};
        wrap_next = (out == LAST_STATE);
        if (illegal) begin
            out_next = '0;
        end
    end

    // Ring and wrap registers; asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            out  <= out_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_johnson_counter_16.sv
// Directed bench for johnson_counter_16: reset, full sequence, wrap timing,
// asynchronous mid-count reset, illegal-state recovery and phase spot checks.
module tb_johnson_counter_16;

  logic        clk;
  logic        reset;
  logic [15:0] out;
  logic [4:0]  phase;
  logic        wrap;
  logic        illegal;

  int checks;
  int errors;

  johnson_counter_16 dut (
    .clk     (clk),
    .reset   (reset),
    .out     (out),
    .phase   (phase),
    .wrap    (wrap),
    .illegal (illegal)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected ring value k edges after leaving reset: first the low bits fill
  // with ones, then ones drain out of the low end.
  function automatic logic [15:0] exp_ring(input int k);
    int m;
    logic [15:0] v;
    m = k % 32;
    if (m <= 16) v = 16'((32'h1 << m) - 32'h1);
    else         v = 16'hFFFF << (m - 16);
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out !== 16'h0000 || phase !== 5'd0 || wrap !== 1'b0 || illegal !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: out=%h phase=%0d wrap=%b illegal=%b, required out=0000 phase=0 wrap=0 illegal=0",
                 i, out, phase, wrap, illegal);
      end
    end
  endtask

  task automatic test_sequence();
    logic [15:0] prev;
    logic [15:0] e;
    apply_reset();
    prev = 16'h0000;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      e = exp_ring(k);
      checks++;
      if (out !== e || phase !== 5'(k % 32) || illegal !== 1'b0) begin
        errors++;
        $display("FAIL sequence edge %0d: out=%h phase=%0d illegal=%b, required out=%h phase=%0d illegal=0",
                 k, out, phase, illegal, e, k % 32);
      end
      checks++;
      if ($countones(out ^ prev) != 1) begin
        errors++;
        $display("FAIL one_bit_change edge %0d: %h -> %h changed %0d bits, required 1",
                 k, prev, out, $countones(out ^ prev));
      end
      checks++;
      if (wrap !== (k == 32)) begin
        errors++;
        $display("FAIL sequence_wrap edge %0d: wrap=%b, required %b", k, wrap, (k == 32));
      end
      prev = out;
    end
  endtask

  task automatic test_wrap();
    int pulses;
    apply_reset();
    pulses = 0;
    for (int k = 1; k <= 96; k++) begin
      @(posedge clk);
      #1;
      if (wrap === 1'b1) pulses++;
      checks++;
      if (wrap !== (k % 32 == 0)) begin
        errors++;
        $display("FAIL wrap_timing edge %0d: wrap=%b, required %b", k, wrap, (k % 32 == 0));
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL wrap_count: saw %0d pulses, required 3", pulses);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 1; k <= 8; k++) @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h00FF) begin
      errors++;
      $display("FAIL async_pre: out=%h, required 00FF", out);
    end
    // Assert reset between edges; the ring must clear without a clock.
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || wrap !== 1'b0 || phase !== 5'd0) begin
      errors++;
      $display("FAIL async_clear: out=%h wrap=%b phase=%0d, required out=0000 wrap=0 phase=0",
               out, wrap, phase);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0001 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_restart: out=%h wrap=%b, required out=0001 wrap=0", out, wrap);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    @(posedge clk);
    @(negedge clk);
    force dut.out = 16'h0005;
    #1;
    checks++;
    if (illegal !== 1'b1 || phase !== 5'd0) begin
      errors++;
      $display("FAIL illegal_detect: illegal=%b phase=%0d, required illegal=1 phase=0", illegal, phase);
    end
    release dut.out;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000 || illegal !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL illegal_recover: out=%h illegal=%b wrap=%b, required out=0000 illegal=0 wrap=0",
               out, illegal, wrap);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0001 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL illegal_resume: out=%h wrap=%b, required out=0001 wrap=0", out, wrap);
    end
  endtask

  task automatic test_phase();
    logic [15:0] vec_v [6];
    logic [4:0]  vec_p [6];
    logic        vec_i [6];
    vec_v[0] = 16'h7FFF; vec_p[0] = 5'd15; vec_i[0] = 1'b0;
    vec_v[1] = 16'hFFFF; vec_p[1] = 5'd16; vec_i[1] = 1'b0;
    vec_v[2] = 16'hFFF0; vec_p[2] = 5'd20; vec_i[2] = 1'b0;
    vec_v[3] = 16'h8000; vec_p[3] = 5'd31; vec_i[3] = 1'b0;
    vec_v[4] = 16'hF0F0; vec_p[4] = 5'd0;  vec_i[4] = 1'b1;
    vec_v[5] = 16'h0100; vec_p[5] = 5'd0;  vec_i[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      force dut.out = vec_v[i];
      #1;
      checks++;
      if (phase !== vec_p[i] || illegal !== vec_i[i]) begin
        errors++;
        $display("FAIL phase_decode %h: phase=%0d illegal=%b, required phase=%0d illegal=%b",
                 vec_v[i], phase, illegal, vec_p[i], vec_i[i]);
      end
      release dut.out;
      reset = 1'b0;
      #1;
      reset = 1'b1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    test_reset();
    test_sequence();
    test_wrap();
    test_async_reset();
    test_illegal();
    test_phase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
